// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl: upstream stage of the password lock.
// Collects a 4-digit keypad code (one nibble per valid/ready handshake),
// compares it with the stored CODE, and drives a timed unlock level on a
// match. Consecutive wrong entries are counted; reaching MAX_FAIL starts a
// timed alarm lockout during which keys and clr are ignored.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   key_valid  in   keypad offers a digit
//   key_data   in   [3:0] digit value
//   key_ready  out  block accepts a digit this cycle (combinational)
//   clr        in   abort entry / relock early
//   unlock     out  door unlocked level (registered)
//   bad_code   out  one-cycle pulse on a wrong entry (registered)
//   alarm      out  lockout active level (registered)
//   fail_cnt   out  [2:0] consecutive wrong entries (registered)
//   digit_idx  out  [1:0] digits captured in the current entry (registered)

module keypad_lock_ctrl #(
   parameter logic [15:0] CODE           = 16'h1E62,
   parameter int unsigned UNLOCK_CYCLES  = 50,
   parameter int unsigned MAX_FAIL       = 3,
   parameter int unsigned LOCKOUT_CYCLES = 100,
   parameter int unsigned ENTRY_TIMEOUT  = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_data,
   output logic       key_ready,
   input  logic       clr,
   output logic       unlock,
   output logic       bad_code,
   output logic       alarm,
   output logic [2:0] fail_cnt,
   output logic [1:0] digit_idx
);

   // One shared timer serves the gap, unlock and lockout intervals, since
   // only one of them is ever running; it is sized for the largest.
   localparam int unsigned TMAX_UL = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                                     UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int unsigned TMAX    = (TMAX_UL > ENTRY_TIMEOUT) ?
                                     TMAX_UL : ENTRY_TIMEOUT;
   localparam int unsigned TW      = $clog2(TMAX + 1);

   localparam logic [TW-1:0] UNLOCK_LAST  = TW'(UNLOCK_CYCLES - 1);
   localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [TW-1:0] ENTRY_LAST   = TW'(ENTRY_TIMEOUT - 1);
   localparam logic [2:0]    FAIL_MAX     = 3'(MAX_FAIL);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ENTRY   = 3'd1,
      CHECK   = 3'd2,
      OPEN    = 3'd3,
      LOCKOUT = 3'd4
   } state_t;

   state_t        state;
   logic [3:0]    digits [4];
   logic [TW-1:0] timer;
   logic          accept;
   logic [15:0]   entered;
   logic [2:0]    fail_next;

   // Ready only while collecting digits; clr withdraws it so an aborting
   // cycle can never also capture a digit.
   assign key_ready = ((state == IDLE) || (state == ENTRY)) && !clr;
   assign accept    = key_valid && key_ready;

   // Digit 0 (first entered) lands in the most significant nibble.
   assign entered   = {digits[0], digits[1], digits[2], digits[3]};

   // Saturating increment of the failure counter.
   assign fail_next = (fail_cnt >= FAIL_MAX) ? FAIL_MAX : fail_cnt + 3'd1;

   // Lock controller FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         unlock    <= 1'b0;
         alarm     <= 1'b0;
         bad_code  <= 1'b0;
         fail_cnt  <= 3'd0;
         digit_idx <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            digits[i] <= 4'h0;
         end
      end else begin
         bad_code <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  digits[0] <= key_data;
                  digit_idx <= 2'd1;
                  timer     <= '0;
                  state     <= ENTRY;
               end
            end

            // clr beats a same-cycle digit, which beats the gap timeout.
            ENTRY: begin
               if (clr) begin
                  digit_idx <= 2'd0;
                  timer     <= '0;
                  state     <= IDLE;
               end else if (accept) begin
                  digits[digit_idx] <= key_data;
                  timer             <= '0;
                  if (digit_idx == 2'd3) begin
                     digit_idx <= 2'd0;
                     state     <= CHECK;
                  end else begin
                     digit_idx <= digit_idx + 2'd1;
                  end
               end else if (timer == ENTRY_LAST) begin
                  digit_idx <= 2'd0;
                  timer     <= '0;
                  state     <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            CHECK: begin
               timer <= '0;
               if (entered == CODE) begin
                  fail_cnt <= 3'd0;
                  unlock   <= 1'b1;
                  state    <= OPEN;
               end else begin
                  bad_code <= 1'b1;
                  fail_cnt <= fail_next;
                  if (fail_next == FAIL_MAX) begin
                     alarm <= 1'b1;
                     state <= LOCKOUT;
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            // Timer counts cycles already spent open; last one releases.
            OPEN: begin
               if (clr || (timer == UNLOCK_LAST)) begin
                  unlock <= 1'b0;
                  timer  <= '0;
                  state  <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            // Keys and clr are deliberately ignored until the alarm expires.
            LOCKOUT: begin
               if (timer == LOCKOUT_LAST) begin
                  alarm    <= 1'b0;
                  fail_cnt <= 3'd0;
                  timer    <= '0;
                  state    <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            default: begin
               unlock    <= 1'b0;
               alarm     <= 1'b0;
               digit_idx <= 2'd0;
               timer     <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb_keypad_lock_ctrl: directed, table-driven bench for keypad_lock_ctrl.
// Each table row gives one cycle of inputs, the key_ready expected during
// that cycle, and the registered outputs expected after its clock edge.
// Lockout, reset-during-lockout and post-lockout unlock are hand sequences.
//
// Ports: none (top-level bench).

module tb_keypad_lock_ctrl;

   localparam logic [15:0] CODE  = 16'h1E62;
   localparam logic [15:0] WRONG = 16'h1E63;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key_valid;
   logic [3:0] key_data;
   logic       key_ready;
   logic       clr;
   logic       unlock;
   logic       bad_code;
   logic       alarm;
   logic [2:0] fail_cnt;
   logic [1:0] digit_idx;

   int n_cmp  = 0;
   int n_fail = 0;
   logic rdy_s;

   keypad_lock_ctrl #(
      .CODE           (CODE),
      .UNLOCK_CYCLES  (5),
      .MAX_FAIL       (3),
      .LOCKOUT_CYCLES (8),
      .ENTRY_TIMEOUT  (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_data  (key_data),
      .key_ready (key_ready),
      .clr       (clr),
      .unlock    (unlock),
      .bad_code  (bad_code),
      .alarm     (alarm),
      .fail_cnt  (fail_cnt),
      .digit_idx (digit_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst_n;
      logic       valid;
      logic       clr;
      logic [3:0] data;
      logic       rdy;
      logic       unl;
      logic       bad;
      logic       alm;
      logic [2:0] fc;
      logic [1:0] idx;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, input logic c, input logic [3:0] d,
                               input logic rdy, input logic unl, input logic bad,
                               input logic alm, input logic [2:0] fc,
                               input logic [1:0] idx);
      vec_t r;
      r.rst_n = 1'b1; r.valid = v; r.clr = c; r.data = d;
      r.rdy = rdy; r.unl = unl; r.bad = bad; r.alm = alm; r.fc = fc; r.idx = idx;
      return r;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle (starting just after an edge), sample key_ready before
   // the next edge, then return just after that edge.
   task automatic cycle(input logic r, input logic v, input logic c, input logic [3:0] d);
      rst_n = r; key_valid = v; clr = c; key_data = d;
      #1;
      rdy_s = key_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outs(input string tag, input logic unl, input logic bad,
                           input logic alm, input logic [2:0] fc, input logic [1:0] idx);
      chk({tag, ".unlock"},    8'(unlock),    8'(unl));
      chk({tag, ".bad_code"},  8'(bad_code),  8'(bad));
      chk({tag, ".alarm"},     8'(alarm),     8'(alm));
      chk({tag, ".fail_cnt"},  8'(fail_cnt),  8'(fc));
      chk({tag, ".digit_idx"}, 8'(digit_idx), 8'(idx));
   endtask

   // Four back-to-back digits, each must be accepted.
   task automatic enter_code(input string tag, input logic [15:0] c);
      logic [3:0] d;
      for (int k = 0; k < 4; k++) begin
         d = c[15 - 4*k -: 4];
         cycle(1'b1, 1'b1, 1'b0, d);
         chk($sformatf("%s.rdy%0d", tag, k), 8'(rdy_s), 8'd1);
      end
   endtask

   // Three wrong entries; the third must start lockout.
   task automatic three_wrong(input string tag);
      for (int n = 1; n <= 3; n++) begin
         enter_code($sformatf("%s.w%0d", tag, n), WRONG);
         cycle(1'b1, 1'b0, 1'b0, 4'h0);
         chk($sformatf("%s.w%0d.check_rdy", tag, n), 8'(rdy_s), 8'd0);
         chk_outs($sformatf("%s.w%0d", tag, n), 1'b0, 1'b1, (n == 3), 3'(n), 2'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; key_valid = 1'b0; clr = 1'b0; key_data = 4'h0;

      // Reset with keys offered: nothing captured, everything cleared.
      @(posedge clk); #1;
      cycle(1'b0, 1'b1, 1'b0, 4'h1);
      chk_outs("reset", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);

      //             v  c  d     rdy unl bad alm fc  idx
      // correct code, key during CHECK and OPEN ignored, 5-cycle unlock
      vecs.push_back(mk(1, 0, 4'h1, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 4'hE, 1, 0, 0, 0, 0, 2));
      vecs.push_back(mk(1, 0, 4'h6, 1, 0, 0, 0, 0, 3));
      vecs.push_back(mk(1, 0, 4'h2, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 4'h5, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 4'h1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 0, 0));
      // wrong code: single bad_code pulse, fail_cnt=1
      vecs.push_back(mk(1, 0, 4'h1, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 4'hE, 1, 0, 0, 0, 0, 2));
      vecs.push_back(mk(1, 0, 4'h6, 1, 0, 0, 0, 0, 3));
      vecs.push_back(mk(1, 0, 4'h3, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 0, 1, 0, 1, 0));
      // ready right after the pulse; start of the timeout scenario
      vecs.push_back(mk(1, 0, 4'h1, 1, 0, 0, 0, 1, 1));
      vecs.push_back(mk(1, 0, 4'hE, 1, 0, 0, 0, 1, 2));
      vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 1, 2));
      vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 1, 2));
      vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 1, 2));
      vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 1, 0));
      // recovery: correct code clears fail_cnt; clr on 2nd OPEN cycle
      vecs.push_back(mk(1, 0, 4'h1, 1, 0, 0, 0, 1, 1));
      vecs.push_back(mk(1, 0, 4'hE, 1, 0, 0, 0, 1, 2));
      vecs.push_back(mk(1, 0, 4'h6, 1, 0, 0, 0, 1, 3));
      vecs.push_back(mk(1, 0, 4'h2, 1, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 4'h0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 0, 0));
      // clr together with the 3rd digit: not accepted, back to IDLE
      vecs.push_back(mk(1, 0, 4'h1, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 4'hE, 1, 0, 0, 0, 0, 2));
      vecs.push_back(mk(1, 1, 4'h6, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 4'h6, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 1, 4'h0, 0, 0, 0, 0, 0, 0));

      foreach (vecs[i]) begin
         cycle(vecs[i].rst_n, vecs[i].valid, vecs[i].clr, vecs[i].data);
         chk($sformatf("row%0d.key_ready", i), 8'(rdy_s), 8'(vecs[i].rdy));
         chk_outs($sformatf("row%0d", i), vecs[i].unl, vecs[i].bad, vecs[i].alm,
                  vecs[i].fc, vecs[i].idx);
      end

      // Lockout: alarm for 8 cycles, keys and clr ignored throughout.
      three_wrong("lock");
      for (int i = 1; i <= 7; i++) begin
         cycle(1'b1, 1'b1, i[0], 4'h1);
         chk($sformatf("lock.c%0d.key_ready", i), 8'(rdy_s), 8'd0);
         chk_outs($sformatf("lock.c%0d", i), 1'b0, 1'b0, 1'b1, 3'd3, 2'd0);
      end
      cycle(1'b1, 1'b1, 1'b0, 4'h1);
      chk("lock.exit.key_ready", 8'(rdy_s), 8'd0);
      chk_outs("lock.exit", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);

      // Correct entry after lockout unlocks.
      enter_code("post", CODE);
      cycle(1'b1, 1'b0, 1'b0, 4'h0);
      chk_outs("post", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
      cycle(1'b1, 1'b0, 1'b1, 4'h0);
      chk_outs("post.clr", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);

      // Reset during lockout with fail_cnt=3.
      three_wrong("rst");
      cycle(1'b1, 1'b0, 1'b0, 4'h0);
      chk_outs("rst.pre", 1'b0, 1'b0, 1'b1, 3'd3, 2'd0);
      cycle(1'b0, 1'b0, 1'b0, 4'h0);
      chk_outs("rst.post", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
      cycle(1'b1, 1'b1, 1'b0, 4'h1);
      chk("rst.key_ready", 8'(rdy_s), 8'd1);
      chk_outs("rst.accept", 1'b0, 1'b0, 1'b0, 3'd0, 2'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
